// File: rtl/regfile_debug_access_ctrl.sv
// Arbiter and access guard in front of a shared register-file port.
//
// Serves a functional and a debug requester through one external register
// file with a single write port and asynchronous read. When both requesters
// are pending, grants alternate between them. Debug accesses at or above
// SENS_BASE are denied unless the key-unlock FSM is UNLOCKED. Repeated wrong
// keys force a timed lockout, and an unlocked session relocks itself after
// IDLE_TIMEOUT cycles without a debug grant.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   func_req/we/addr/wdata -> func_ack, func_rdata     functional requester
//   dbg_req/we/addr/wdata  -> dbg_ack, dbg_err, dbg_rdata  debug requester
//   dbg_key_valid, dbg_key, dbg_relock                 unlock / relock control
//   rf_we, rf_addr, rf_wdata, rf_rdata                 register-file port
//   unlocked, lockout, fail_cnt                        lock status
//
// Access FSM
//   state | meaning
//   IDLE  | waiting for a request; grant and latch the command here
//   ISSUE | command on rf_*; rf_we strobes if permitted; read data captured
//   ACK   | granted requester's ack pulses; back to IDLE
//
// Lock FSM
//   state    | meaning
//   LOCKED   | sensitive debug window closed; key strobes are evaluated
//   UNLOCKED | sensitive window open; idle timer counts down to relock
//   LOCKOUT  | too many wrong keys; key and relock ignored until timer expires
module regfile_debug_access_ctrl #(
  parameter int unsigned          ADDR_W       = 8,
  parameter int unsigned          DATA_W       = 32,
  parameter logic [ADDR_W-1:0]    SENS_BASE    = 8'hF0,
  parameter logic [DATA_W-1:0]    UNLOCK_KEY   = 32'hA5C3_5A3C,
  parameter int unsigned          MAX_FAIL     = 3,
  parameter int unsigned          LOCKOUT_CYC  = 1024,
  parameter int unsigned          IDLE_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              func_req,
  input  logic              func_we,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic [DATA_W-1:0] func_wdata,
  output logic              func_ack,
  output logic [DATA_W-1:0] func_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_key_valid,
  input  logic [DATA_W-1:0] dbg_key,
  input  logic              dbg_relock,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              unlocked,
  output logic              lockout,
  output logic [1:0]        fail_cnt
);

  // One down-counter serves both the idle and the lockout timer; the two are
  // never live at the same time.
  localparam int unsigned TMR_MAX = (LOCKOUT_CYC > IDLE_TIMEOUT) ? LOCKOUT_CYC : IDLE_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0] IDLE_LOAD    = TMR_W'(IDLE_TIMEOUT - 1);
  localparam logic [1:0]       FAIL_LAST    = 2'(MAX_FAIL - 1);

  typedef enum logic [1:0] {ACC_IDLE, ACC_ISSUE, ACC_ACK} acc_state_e;
  typedef enum logic [1:0] {LK_LOCKED, LK_UNLOCKED, LK_LOCKOUT} lock_state_e;

  acc_state_e        acc_state_q, acc_state_d;
  lock_state_e       lock_state_q, lock_state_d;
  logic              gnt_dbg_q, gnt_dbg_d;
  logic              last_dbg_q, last_dbg_d;
  logic              we_q, we_d;
  logic              deny_q, deny_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] func_rdata_q, func_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [1:0]        fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              pick_dbg;
  logic              dbg_grant;

  // Debug wins when alone, or when both pend and functional was served last.
  assign pick_dbg  = dbg_req && (!func_req || !last_dbg_q);
  assign dbg_grant = (acc_state_q == ACC_IDLE) && pick_dbg;

  always_comb begin
    acc_state_d  = acc_state_q;
    gnt_dbg_d    = gnt_dbg_q;
    last_dbg_d   = last_dbg_q;
    we_d         = we_q;
    deny_d       = deny_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    func_rdata_d = func_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (acc_state_q)
      ACC_IDLE: begin
        if (func_req || dbg_req) begin
          gnt_dbg_d   = pick_dbg;
          last_dbg_d  = pick_dbg;
          we_d        = pick_dbg ? dbg_we    : func_we;
          addr_d      = pick_dbg ? dbg_addr  : func_addr;
          wdata_d     = pick_dbg ? dbg_wdata : func_wdata;
          // Permission is frozen here; a later relock cannot cancel it.
          deny_d      = pick_dbg && (dbg_addr >= SENS_BASE) &&
                        (lock_state_q != LK_UNLOCKED);
          acc_state_d = ACC_ISSUE;
        end
      end
      ACC_ISSUE: begin
        if (gnt_dbg_q) dbg_rdata_d  = deny_q ? '0 : rf_rdata;
        else           func_rdata_d = rf_rdata;
        acc_state_d = ACC_ACK;
      end
      ACC_ACK:  acc_state_d = ACC_IDLE;
      default:  acc_state_d = ACC_IDLE;
    endcase
  end

  always_comb begin
    lock_state_d = lock_state_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    case (lock_state_q)
      LK_LOCKED: begin
        if (dbg_key_valid) begin
          if (dbg_key == UNLOCK_KEY) begin
            lock_state_d = LK_UNLOCKED;
            fail_cnt_d   = '0;
            timer_d      = IDLE_LOAD;
          end else if (fail_cnt_q == FAIL_LAST) begin
            lock_state_d = LK_LOCKOUT;
            fail_cnt_d   = '0;
            timer_d      = LOCKOUT_LOAD;
          end else begin
            fail_cnt_d   = fail_cnt_q + 2'd1;
          end
        end
      end
      LK_UNLOCKED: begin
        if (dbg_relock)               lock_state_d = LK_LOCKED;
        else if (dbg_grant)           timer_d      = IDLE_LOAD;
        else if (timer_q == '0)       lock_state_d = LK_LOCKED;
        else                          timer_d      = timer_q - TMR_W'(1);
      end
      LK_LOCKOUT: begin
        if (timer_q == '0)            lock_state_d = LK_LOCKED;
        else                          timer_d      = timer_q - TMR_W'(1);
      end
      default:                        lock_state_d = LK_LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state_q  <= ACC_IDLE;
      lock_state_q <= LK_LOCKED;
      gnt_dbg_q    <= 1'b0;
      last_dbg_q   <= 1'b1;
      we_q         <= 1'b0;
      deny_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      func_rdata_q <= '0;
      dbg_rdata_q  <= '0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
    end else begin
      acc_state_q  <= acc_state_d;
      lock_state_q <= lock_state_d;
      gnt_dbg_q    <= gnt_dbg_d;
      last_dbg_q   <= last_dbg_d;
      we_q         <= we_d;
      deny_q       <= deny_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      func_rdata_q <= func_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
    end
  end

  // rf_we decodes straight from state so an async reset kills it at once.
  assign rf_we      = (acc_state_q == ACC_ISSUE) && we_q && !deny_q;
  assign rf_addr    = addr_q;
  assign rf_wdata   = wdata_q;
  assign func_ack   = (acc_state_q == ACC_ACK) && !gnt_dbg_q;
  assign dbg_ack    = (acc_state_q == ACC_ACK) && gnt_dbg_q;
  assign dbg_err    = dbg_ack && deny_q;
  assign func_rdata = func_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign unlocked   = (lock_state_q == LK_UNLOCKED);
  assign lockout    = (lock_state_q == LK_LOCKOUT);
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: doc/regfile_debug_access_ctrl.md
Name: regfile_debug_access_ctrl

Overview:
- Controller in front of the shared register-file write/read port; arbitrates between the functional requester and the debug requester.
- Gates debug access to the sensitive address window behind a key-unlock state machine.
- Enforces a failed-attempt lockout and an idle auto-relock.
- The register file itself is external: single write port, asynchronous read.

Parameters:
ADDR_W, 8, register-file address width
DATA_W, 32, data width
SENS_BASE, 8'hF0, lowest sensitive address; addr >= SENS_BASE is sensitive
UNLOCK_KEY, 32'hA5C3_5A3C, debug unlock key
MAX_FAIL, 3, wrong keys before lockout
LOCKOUT_CYC, 1024, lockout duration in cycles
IDLE_TIMEOUT, 256, cycles without a granted debug access before auto-relock

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
func_req  input  1  functional request, held until func_ack
func_we  input  1  1=write, 0=read
func_addr  input  ADDR_W  functional address
func_wdata  input  DATA_W  functional write data
func_ack  output  1  one-cycle completion pulse
func_rdata  output  DATA_W  read data, valid with func_ack
dbg_req  input  1  debug request, held until dbg_ack
dbg_we  input  1  1=write, 0=read
dbg_addr  input  ADDR_W  debug address
dbg_wdata  input  DATA_W  debug write data
dbg_ack  output  1  one-cycle completion pulse
dbg_err  output  1  access denied, valid with dbg_ack
dbg_rdata  output  DATA_W  read data, valid with dbg_ack
dbg_key_valid  input  1  one-cycle key strobe
dbg_key  input  DATA_W  key value
dbg_relock  input  1  one-cycle relock strobe
rf_we  output  1  register-file write strobe
rf_addr  output  ADDR_W  register-file address
rf_wdata  output  DATA_W  register-file write data
rf_rdata  input  DATA_W  register-file async read data
unlocked  output  1  1 in UNLOCKED
lockout  output  1  1 in LOCKOUT
fail_cnt  output  2  wrong-key count

Behaviour:
- Reset (rst_n low, asynchronous):
  - Lock FSM = LOCKED; access FSM = IDLE; last_grant = debug.
  - All outputs 0; rf_we drops immediately.
  - Any in-flight access is aborted with no ack.
- Access FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester opposite to last_grant (round-robin); functional wins first after reset.
  - Grant registers addr/we/wdata; go to ISSUE.
- ISSUE (grant cycle + 1):
  - rf_addr/rf_wdata driven; rf_we = we for exactly one cycle.
  - rf_rdata captured into the requester's rdata register; go to ACK.
- ACK (grant cycle + 2):
  - The granted requester's ack pulses for one cycle; return to IDLE.
  - Requester must deassert req by the following cycle; a req still high in IDLE is a new request.
- Permission check happens at grant, on the lock state in the grant cycle:
  - Debug access to a sensitive address is denied unless state is UNLOCKED.
  - Denied access: rf_we stays 0, dbg_rdata = 0, dbg_err = 1 with dbg_ack; same 2-cycle latency.
  - A permitted access completes even if a relock happens mid-flight.
- Unconditional accesses:
  - Functional access is never denied.
  - Debug access to a non-sensitive address is always permitted, including during LOCKOUT.
- Lock FSM states: LOCKED, UNLOCKED, LOCKOUT.
- LOCKED + dbg_key_valid:
  - key == UNLOCK_KEY: go to UNLOCKED; fail_cnt = 0; idle timer = IDLE_TIMEOUT-1.
  - Mismatch: fail_cnt+1. When the count reaches MAX_FAIL, go to LOCKOUT, lockout timer = LOCKOUT_CYC-1, fail_cnt = 0.
- UNLOCKED:
  - Idle timer reloads on every debug grant and decrements otherwise; at 0, go to LOCKED.
  - dbg_relock goes to LOCKED next cycle. Relock beats a simultaneous key strobe.
  - Key strobes are ignored.
- LOCKOUT:
  - Key strobes and relock are ignored; no effect on fail_cnt.
  - Timer decrements; at 0, go to LOCKED.
- Timers saturate at 0; the lock state machine is independent of the access state machine.

Test Plan:
- Reset, then func read addr 0x10 with rf_rdata=0x1234 -> rf_addr=0x10 at grant+1, func_ack and func_rdata=0x1234 at grant+2, rf_we never high.
- Locked debug write addr 0xF4 data 0xDEADBEEF -> rf_we stays 0, dbg_ack+dbg_err at grant+2; debug write addr 0x20 -> rf_we pulse at grant+1, dbg_err=0.
- Key 0xA5C35A3C -> unlocked=1 next cycle; debug write 0xF4 succeeds; 256 idle cycles -> unlocked=0; relock during in-flight write still produces rf_we.
- Three wrong keys -> fail_cnt 1,2, then lockout=1; correct key during lockout ignored; lockout=0 after 1024 cycles, state LOCKED.
- func_req and dbg_req both held for 4 transactions -> grants alternate func, dbg, func, dbg.
- rst_n low during ISSUE of a write -> rf_we drops immediately, no ack, unlocked=0, fail_cnt=0.
